// File: rtl/if_id_queue_pkg.sv
// Shared constants for the IF->ID instruction queue: reset PC, NOP encoding,
// data width and the trap-flag bundle layout.
package if_id_queue_pkg;

    localparam int          CPU_XLEN     = 32;
    localparam logic [31:0] CPU_RST_ADDR = 32'h8000_0000;
    localparam logic [31:0] CPU_NOP      = 32'h0000_0013;

    // Widen TRAP_W and add an index here when new per-instruction flags appear.
    localparam int TRAP_W     = 3;
    localparam int TRAP_INT   = 0;
    localparam int TRAP_EXP   = 1;
    localparam int TRAP_MISAL = 2;

endpackage

// File: rtl/if_id_queue_mem.sv
// Queue storage: DEPTH entries, one synchronous write port and one
// asynchronous read port. Contents are not reset.
module if_id_queue_mem #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 67,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// DEPTH-entry IF->ID instruction queue with flush and stall handling.
// Optional same-cycle empty bypass is enabled by defining IFQ_BYPASS_EN.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int              XLEN     = CPU_XLEN,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RST_ADDR = CPU_RST_ADDR,
    parameter logic [XLEN-1:0] NOP_INST = CPU_NOP
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pipe_stall,
    input  logic                     ex_bj_flag,
    input  logic                     if_valid,
    output logic                     if_ready,
    input  logic [XLEN-1:0]          if_pc,
    input  logic [XLEN-1:0]          if_inst,
    input  logic                     if_int_flag,
    input  logic                     if_exp_flag,
    input  logic                     if_inst_addr_misal,
    input  logic                     id_allowin,
    output logic                     id_valid,
    output logic [XLEN-1:0]          id_pc,
    output logic [XLEN-1:0]          id_inst,
    output logic                     id_int_flag,
    output logic                     id_exp_flag,
    output logic                     id_inst_addr_misal,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = 2 * XLEN + TRAP_W;

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              full;
    logic              empty;
    logic              push;
    logic              pop;
    logic              byp;
    logic              byp_pass;
    logic              wr_en;
    logic              rd_en;
    logic [TRAP_W-1:0] if_trap;
    logic [TRAP_W-1:0] head_trap;
    logic [TRAP_W-1:0] out_trap;
    logic [XLEN-1:0]   head_pc;
    logic [XLEN-1:0]   head_inst;
    logic [EW-1:0]     wdata;
    logic [EW-1:0]     rdata;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        if_trap             = '0;
        if_trap[TRAP_INT]   = if_int_flag;
        if_trap[TRAP_EXP]   = if_exp_flag;
        if_trap[TRAP_MISAL] = if_inst_addr_misal;
    end

`ifdef IFQ_BYPASS_EN
    assign byp = empty & if_valid & ~ex_bj_flag & ~pipe_stall;
`else
    assign byp = 1'b0;
`endif

    assign if_ready = ~full & ~ex_bj_flag;
    assign id_valid = (~empty & ~pipe_stall & ~ex_bj_flag) | byp;

    assign push     = if_valid & if_ready;
    assign pop      = id_valid & id_allowin;
    // A bypassed entry consumed the same cycle never touches storage.
    assign byp_pass = byp & id_allowin;
    assign wr_en    = push & ~byp_pass;
    assign rd_en    = pop & ~byp_pass;

    assign wdata = {if_pc, if_inst, if_trap};

    if_id_queue_mem #(
        .DEPTH (DEPTH),
        .WIDTH (EW),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign head_pc   = rdata[EW-1 -: XLEN];
    assign head_inst = rdata[TRAP_W +: XLEN];
    assign head_trap = rdata[TRAP_W-1:0];

    always_comb begin
        id_pc    = RST_ADDR;
        id_inst  = NOP_INST;
        out_trap = '0;
        if (byp) begin
            id_pc    = if_pc;
            id_inst  = if_inst;
            out_trap = if_trap;
        end else if (!empty) begin
            id_pc    = head_pc;
            id_inst  = head_inst;
            out_trap = head_trap;
        end
    end

    assign id_int_flag        = out_trap[TRAP_INT];
    assign id_exp_flag        = out_trap[TRAP_EXP];
    assign id_inst_addr_misal = out_trap[TRAP_MISAL];

    always_ff @(posedge clk) begin
        if (!rst_n || ex_bj_flag) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign q_count = count;

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus random traffic
// compared every cycle against a queue-based model.
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [2:0]  fl;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_stall = 1'b0;
    logic        ex_bj_flag = 1'b0;
    logic        if_valid = 1'b0;
    logic        if_ready;
    logic [31:0] if_pc = '0;
    logic [31:0] if_inst = '0;
    logic        if_int_flag = 1'b0;
    logic        if_exp_flag = 1'b0;
    logic        if_inst_addr_misal = 1'b0;
    logic        id_allowin = 1'b0;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_int_flag;
    logic        id_exp_flag;
    logic        id_inst_addr_misal;
    logic [2:0]  q_count;

    int checks = 0;
    int errors = 0;
    bit model_ok = 1'b0;
    ent_t q[$];

    always #5 clk = ~clk;

    if_id_queue #(.DEPTH(DEPTH)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .pipe_stall         (pipe_stall),
        .ex_bj_flag         (ex_bj_flag),
        .if_valid           (if_valid),
        .if_ready           (if_ready),
        .if_pc              (if_pc),
        .if_inst            (if_inst),
        .if_int_flag        (if_int_flag),
        .if_exp_flag        (if_exp_flag),
        .if_inst_addr_misal (if_inst_addr_misal),
        .id_allowin         (id_allowin),
        .id_valid           (id_valid),
        .id_pc              (id_pc),
        .id_inst            (id_inst),
        .id_int_flag        (id_int_flag),
        .id_exp_flag        (id_exp_flag),
        .id_inst_addr_misal (id_inst_addr_misal),
        .q_count            (q_count)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] pc, input logic al);
        if_valid           = v;
        if_pc              = pc;
        if_inst            = pc ^ 32'h13;
        if_int_flag        = 1'b0;
        if_exp_flag        = 1'b0;
        if_inst_addr_misal = 1'b0;
        id_allowin         = al;
    endtask

    // Compare against the model, advance one clock, update the model.
    task automatic step();
        ent_t e;
        ent_t inp;
        bit   bp;
        bit   ev;
        bit   er;
        bp  = 1'b0;
        ev  = 1'b0;
        er  = 1'b0;
        inp = '{if_pc, if_inst,
                {if_inst_addr_misal, if_exp_flag, if_int_flag}};
        #1;
        if (model_ok) begin
            er = (q.size() < DEPTH) && !ex_bj_flag;
`ifdef IFQ_BYPASS_EN
            bp = (q.size() == 0) && if_valid && !ex_bj_flag && !pipe_stall;
`endif
            ev = ((q.size() > 0) && !pipe_stall && !ex_bj_flag) || bp;
            if (bp) e = inp;
            else if (q.size() > 0) e = q[0];
            else e = '{CPU_RST_ADDR, CPU_NOP, 3'b000};
            chk("if_ready", {31'b0, if_ready}, {31'b0, er});
            chk("id_valid", {31'b0, id_valid}, {31'b0, ev});
            chk("id_pc", id_pc, e.pc);
            chk("id_inst", id_inst, e.inst);
            chk("id_flags",
                {29'b0, id_inst_addr_misal, id_exp_flag, id_int_flag},
                {29'b0, e.fl});
            chk("q_count", {29'b0, q_count}, q.size());
        end
        @(posedge clk);
        if (!rst_n) begin
            q.delete();
            model_ok = 1'b1;
        end else if (model_ok) begin
            if (ex_bj_flag) begin
                q.delete();
            end else if (!(bp && id_allowin)) begin
                if (ev && id_allowin) void'(q.pop_front());
                if (if_valid && er) q.push_back(inp);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        drv(1'b0, 32'h0, 1'b0);
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rst_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_pc", id_pc, CPU_RST_ADDR);
        chk("rst_inst", id_inst, 32'h13);
        chk("rst_count", {29'b0, q_count}, 32'd0);
        chk("rst_ready", {31'b0, if_ready}, 32'd1);

        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 32'h100 + 32'(4 * i), 1'b0);
            step();
        end
        drv(1'b0, 32'h0, 1'b0);
        #1;
        chk("full_count", {29'b0, q_count}, 32'd4);
        chk("full_ready", {31'b0, if_ready}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            drv(1'b0, 32'h0, 1'b1);
            #1;
            chk("drain_pc", id_pc, 32'h100 + 32'(4 * i));
            step();
        end
        #1;
        chk("drained_valid", {31'b0, id_valid}, 32'd0);
        chk("drained_pc", id_pc, CPU_RST_ADDR);

        drv(1'b1, 32'h400, 1'b0);
        step();
        drv(1'b1, 32'h404, 1'b0);
        step();
        for (int i = 0; i < 12; i++) begin
            drv(1'b1, 32'h408 + 32'(4 * i), 1'b1);
            #1;
            chk("stream_pc", id_pc, 32'h400 + 32'(4 * i));
            step();
        end
        #1;
        chk("stream_count", {29'b0, q_count}, 32'd2);

        drv(1'b1, 32'h1F0, 1'b0);
        step();
        drv(1'b1, 32'hDEAD_0000, 1'b1);
        ex_bj_flag = 1'b1;
        #1;
        chk("flush_valid", {31'b0, id_valid}, 32'd0);
        chk("flush_ready", {31'b0, if_ready}, 32'd0);
        step();
        ex_bj_flag = 1'b0;
        drv(1'b1, 32'h200, 1'b0);
        #1;
        chk("post_flush_count", {29'b0, q_count}, 32'd0);
        chk("post_flush_valid", {31'b0, id_valid}, 32'd0);
        step();
        drv(1'b0, 32'h0, 1'b1);
        #1;
        chk("after_flush_pc", id_pc, 32'h200);
        step();
        #1;
        chk("after_flush_empty", {29'b0, q_count}, 32'd0);

        drv(1'b1, 32'h300, 1'b0);
        step();
        pipe_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drv(1'b1, 32'h304 + 32'(4 * i), 1'b1);
            #1;
            chk("stall_valid", {31'b0, id_valid}, 32'd0);
            chk("stall_pc", id_pc, 32'h300);
            step();
        end
        pipe_stall = 1'b0;
        drv(1'b0, 32'h0, 1'b1);
        #1;
        chk("stall_count", {29'b0, q_count}, 32'd4);
        chk("release_pc", id_pc, 32'h300);
        chk("release_valid", {31'b0, id_valid}, 32'd1);
        for (int i = 0; i < 4; i++) step();

`ifdef IFQ_BYPASS_EN
        drv(1'b1, 32'h40, 1'b1);
        if_exp_flag = 1'b1;
        #1;
        chk("byp_pc", id_pc, 32'h40);
        chk("byp_valid", {31'b0, id_valid}, 32'd1);
        chk("byp_exp", {31'b0, id_exp_flag}, 32'd1);
        step();
        drv(1'b0, 32'h0, 1'b0);
        #1;
        chk("byp_count", {29'b0, q_count}, 32'd0);
`endif

        for (int n = 0; n < 3000; n++) begin
            rst_n              = ($urandom_range(0, 199) != 0);
            ex_bj_flag         = ($urandom_range(0, 19) == 0);
            pipe_stall         = ($urandom_range(0, 7) == 0);
            if_valid           = ($urandom_range(0, 9) < 7);
            id_allowin         = ($urandom_range(0, 9) < 6);
            if_pc              = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            if_inst            = $urandom;
            if_int_flag        = $urandom_range(0, 1) == 1;
            if_exp_flag        = $urandom_range(0, 1) == 1;
            if_inst_addr_misal = $urandom_range(0, 1) == 1;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_queue.md
# if_id_queue

Parametrised IF→ID boundary replacing the single-entry fetch/decode register with a DEPTH-entry instruction queue. It absorbs fetch-side bus latency and decode back-pressure through a valid/ready handshake on both sides, and carries PC, instruction word and per-instruction trap flags. It flushes on an EX branch/jump and freezes its output on a pipeline stall. It sits between the fetch unit (bus response side) and the decoder.

## Interface
- XLEN, 32, data/address width
- DEPTH, 4, queue entries; power of two, ≥2
- RST_ADDR, `CPU_RST_ADDR`, PC presented while empty
- NOP_INST, 32'h0000_0013, instruction presented while empty
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- pipe_stall  in  1  freeze output side; no pop
- ex_bj_flag  in  1  flush: discard all entries and the current push
- if_valid  in  1  fetch offers an entry
- if_ready  out  1  queue accepts; = ~full & ~ex_bj_flag
- if_pc  in  XLEN  fetched PC
- if_inst  in  XLEN  fetched instruction
- if_int_flag, if_exp_flag, if_inst_addr_misal  in  1 each  trap flags
- id_allowin  in  1  decoder accepts head
- id_valid  out  1  head valid; = ~empty & ~pipe_stall & ~ex_bj_flag
- id_pc, id_inst  out  XLEN each  head payload
- id_int_flag, id_exp_flag, id_inst_addr_misal  out  1 each  head flags
- q_count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Push when if_valid & if_ready. Pop when id_valid & id_allowin.
- Circular buffer, wr_ptr/rd_ptr of $clog2(DEPTH) bits. Pointers wrap naturally at DEPTH. Count is tracked separately: +1 on push only, −1 on pop only, unchanged on both.
- Push and pop in the same cycle are legal at any non-full occupancy. At full, if_ready=0 regardless of a pop, so ready never depends on id_allowin.
- Empty: id_pc=RST_ADDR, id_inst=NOP_INST, all flags 0, id_valid=0.
- Flush (ex_bj_flag=1): next cycle count=0 and wr_ptr=rd_ptr=0. The push and pop in the flush cycle are both suppressed. Flush has priority over stall.
- Stall: id_valid=0 and no pop. Pushes continue until full. The payload held at the head is stable.
- Reset: count=0, pointers=0. Outputs take their empty values in the cycle after rst_n is sampled low. Storage contents are not reset. Reset mid-stream discards all entries.

## Timing
- Without bypass: an entry pushed in cycle N is visible at id_* in cycle N+1. Throughput is 1 per cycle.
- if_ready depends only on count and ex_bj_flag, with no combinational path from id_allowin.
- id_valid combinationally depends on pipe_stall/ex_bj_flag (same-cycle kill).
- q_count is registered and updates the cycle after a push/pop/flush.

## Configuration
- IFQ_BYPASS_EN defined: when empty and if_valid & ~ex_bj_flag & ~pipe_stall, id_* is driven combinationally from if_* and id_valid=1.
  - If id_allowin=1, the entry passes through without being written (0-cycle latency, count unchanged).
  - Otherwise it is written normally.
- IFQ_BYPASS_EN undefined: no if_*→id_* combinational path; minimum latency 1 cycle.

## Structure
- Shared package/defines: `CPU_RST_ADDR`, NOP encoding, `XLEN`, and a trap-flag bundle width constant (3) with bit indices INT/EXP/MISAL, so later flag additions widen storage in one place.
- Sub-module: if_id_queue_mem, a DEPTH×(2·XLEN+3) register array with one write port and one asynchronous read port. Pointer/count/handshake logic stays in the top.

## Test plan
- Reset with rst_n=0 for 2 cycles → id_valid=0, id_pc=RST_ADDR, id_inst=32'h13, q_count=0, if_ready=1.
- Push PC 0x100..0x10C back-to-back, id_allowin=0 (DEPTH=4) → q_count=4, if_ready=0. Then id_allowin=1 for 4 cycles → pops 0x100,0x104,0x108,0x10C in order, then empty values.
- Steady stream at count=2 with push+pop every cycle → count stays 2 and order is preserved across pointer wrap for ≥10 entries.
- Count=3, assert ex_bj_flag with if_valid=1 → next cycle count=0 and id_valid=0; the offered entry is never popped. The following push of 0x200 appears alone.
- pipe_stall=1 for 3 cycles with if_valid=1 from count=1 → id_valid=0 throughout, count reaches 4, head payload unchanged. Release → head pops first.
- IFQ_BYPASS_EN, empty, if_valid=1, id_allowin=1, if_pc=0x40 → id_pc=0x40 and id_valid=1 in the same cycle, q_count stays 0. Entry flags if_exp_flag=1 → id_exp_flag=1.
